// File: rtl/dcache_ctrl_if.sv
// dcache_ctrl_if: CPU load/store port and memory line-transfer port of dcache_ctrl.
// slave = the cache controller, master = the CPU/RAM environment around it.
interface dcache_ctrl_if;
  logic         cpu_req;
  logic         cpu_we;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic [3:0]   cpu_be;
  logic [31:0]  cpu_rdata;
  logic         cpu_ready;
  logic         mem_read_op;
  logic         mem_write_op;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be, mem_rdata,
    output cpu_rdata, cpu_ready, mem_read_op, mem_write_op, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be, mem_rdata,
    input  cpu_rdata, cpu_ready, mem_read_op, mem_write_op, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache controller.
// 32-bit CPU word port, 256-bit (8-word) line transfers to the data RAM.
// Optional hit/miss/write-back counters are built when DCACHE_STATS_EN is defined.
module dcache_ctrl #(
  parameter int LINES   = 16,
  parameter int MEM_LAT = 1
) (
  input  logic          CLK,
  input  logic          RST_N,
  dcache_ctrl_if.slave  bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]   hit_cnt,
  output logic [31:0]   miss_cnt,
  output logic [31:0]   wb_cnt
`endif
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 27 - IDX_W;
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LAT - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOOKUP = 2'd1;
  localparam logic [1:0] WB     = 2'd2;
  localparam logic [1:0] REFILL = 2'd3;

  logic [1:0]       state_q;
  logic [TAG_W-1:0] req_tag_q;
  logic [IDX_W-1:0] req_idx_q;
  logic [2:0]       req_word_q;
  logic             req_we_q;
  logic [31:0]      req_wdata_q;
  logic [3:0]       req_be_q;
  logic [CNT_W-1:0] lat_q;
  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;
  logic             ready_q;
  logic [31:0]      rdata_q;

  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [255:0]     data_mem [LINES];

  logic         hit;
  logic         victim_dirty;
  logic         lat_done;
  logic [255:0] line;
  logic [255:0] merged_line;
  logic [31:0]  cur_word;
  logic [31:0]  merged_word;

  // Byte address bits [1:0] never select anything; accesses are whole words.
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.cpu_addr[1:0];

  // Hit detection and store-data merge for the line addressed by the held request.
  // NOTE: every always_comb output is assigned a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    line         = data_mem[req_idx_q];
    hit          = valid_q[req_idx_q] && (tag_mem[req_idx_q] == req_tag_q);
    victim_dirty = valid_q[req_idx_q] && dirty_q[req_idx_q];
    lat_done     = (lat_q == LAT_LAST);
    cur_word     = line[{req_word_q, 5'b0} +: 32];
    merged_word  = cur_word;
    for (int b = 0; b < 4; b++) begin
      if (req_be_q[b]) merged_word[8*b +: 8] = req_wdata_q[8*b +: 8];
    end
    merged_line = line;
    merged_line[{req_word_q, 5'b0} +: 32] = merged_word;
  end

  // Memory-side outputs follow the state directly, so reset drops them at once.
  always_comb begin
    bus.mem_write_op = (state_q == WB);
    bus.mem_read_op  = (state_q == REFILL);
    bus.mem_addr     = '0;
    bus.mem_wdata    = '0;
    unique case (state_q)
      WB: begin
        bus.mem_addr  = {tag_mem[req_idx_q], req_idx_q, 5'b0};
        bus.mem_wdata = line;
      end
      REFILL:  bus.mem_addr = {req_tag_q, req_idx_q, 5'b0};
      default: ;
    endcase
  end

  assign bus.cpu_ready = ready_q;
  assign bus.cpu_rdata = rdata_q;

  // Line data and tags: written on a store hit and on the last refill cycle.
  // NOTE: the arrays carry no reset; a line is only read once its valid bit is set, which is reset.
  always_ff @(posedge CLK) begin
    if (state_q == LOOKUP && hit && req_we_q) begin
      data_mem[req_idx_q] <= merged_line;
    end else if (state_q == REFILL && lat_done) begin
      data_mem[req_idx_q] <= bus.mem_rdata;
      tag_mem[req_idx_q]  <= req_tag_q;
    end
  end

  // Control FSM: request capture, lookup, write-back and refill sequencing.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      req_tag_q   <= '0;
      req_idx_q   <= '0;
      req_word_q  <= '0;
      req_we_q    <= 1'b0;
      req_wdata_q <= '0;
      req_be_q    <= '0;
      lat_q       <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
      ready_q     <= 1'b0;
      rdata_q     <= '0;
    end else begin
      ready_q <= 1'b0;
      rdata_q <= '0;
      unique case (state_q)
        IDLE: begin
          // cpu_req is still high for the request just completed; skip that cycle.
          if (bus.cpu_req && !ready_q) begin
            req_tag_q   <= bus.cpu_addr[31 -: TAG_W];
            req_idx_q   <= bus.cpu_addr[5 +: IDX_W];
            req_word_q  <= bus.cpu_addr[4:2];
            req_we_q    <= bus.cpu_we;
            req_wdata_q <= bus.cpu_wdata;
            req_be_q    <= bus.cpu_be;
            state_q     <= LOOKUP;
          end
        end
        LOOKUP: begin
          lat_q <= '0;
          if (hit) begin
            ready_q <= 1'b1;
            if (req_we_q) dirty_q[req_idx_q] <= 1'b1;
            else          rdata_q            <= cur_word;
            state_q <= IDLE;
          end else if (victim_dirty) begin
            state_q <= WB;
          end else begin
            state_q <= REFILL;
          end
        end
        WB: begin
          if (lat_done) begin
            dirty_q[req_idx_q] <= 1'b0;
            lat_q              <= '0;
            state_q            <= REFILL;
          end else begin
            lat_q <= lat_q + 1'b1;
          end
        end
        REFILL: begin
          if (lat_done) begin
            valid_q[req_idx_q] <= 1'b1;
            dirty_q[req_idx_q] <= 1'b0;
            lat_q              <= '0;
            state_q            <= LOOKUP;
          end else begin
            lat_q <= lat_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  // A LOOKUP entered straight from REFILL is the post-refill revisit, not a new hit.
  logic revisit_q;

  // Event counters; free-running, wrap at 2^32.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      revisit_q <= 1'b0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      wb_cnt    <= '0;
    end else begin
      revisit_q <= (state_q == REFILL);
      if (state_q == LOOKUP) begin
        if (hit && !revisit_q) hit_cnt  <= hit_cnt + 1'b1;
        if (!hit)              miss_cnt <= miss_cnt + 1'b1;
        if (!hit && victim_dirty) wb_cnt <= wb_cnt + 1'b1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed self-checking bench for dcache_ctrl (LINES=16, MEM_LAT=3).
// A transaction-level cache/memory model predicts each cycle's outputs; literal
// expectations pin latencies, data words and write-back contents.
module tb_dcache_ctrl;
  localparam int LINES   = 16;
  localparam int MEM_LAT = 3;
  localparam int IDXW    = 4;

  logic CLK;
  logic RST_N;
  dcache_ctrl_if bus ();

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt, wb_cnt;
  dcache_ctrl #(.LINES(LINES), .MEM_LAT(MEM_LAT)) dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt));
`else
  dcache_ctrl #(.LINES(LINES), .MEM_LAT(MEM_LAT)) dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus));
`endif

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Default RAM contents: each word holds C0DE in the top half and its own address low half.
  function automatic logic [255:0] fill(input logic [31:0] la);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = 32'hC0DE_0000 | ((la + 32'(4*k)) & 32'h0000_FFFF);
    return l;
  endfunction

  // ---------------- RAM (environment) ----------------
  logic [255:0] ram [logic [31:0]];
  always @(negedge CLK) bus.mem_rdata = ram.exists(bus.mem_addr) ? ram[bus.mem_addr] : fill(bus.mem_addr);
  always @(posedge CLK) if (bus.mem_write_op) ram[bus.mem_addr] = bus.mem_wdata;

  // Observation of memory traffic per access, used by literal checks.
  int           wr_cycles, rd_cycles;
  logic [31:0]  wb_addr_seen;
  logic [255:0] wb_data_seen;
  always @(negedge CLK) begin
    if (bus.mem_write_op) begin
      wr_cycles++;
      wb_addr_seen = bus.mem_addr;
      wb_data_seen = bus.mem_wdata;
    end
    if (bus.mem_read_op) rd_cycles++;
  end

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic         ready;
    logic [31:0]  rdata;
    logic         rd;
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
  } exp_t;

  exp_t         exp_q [$];
  logic         m_valid [LINES];
  logic         m_dirty [LINES];
  logic [31:0]  m_tag   [LINES];
  logic [255:0] m_data  [LINES];
  logic [255:0] m_mem   [logic [31:0]];
  int           m_hits, m_misses, m_wbs;

  function automatic exp_t mk(input logic r, input logic [31:0] rd_w, input logic rd,
                              input logic wr, input logic [31:0] a, input logic [255:0] wd);
    exp_t e;
    e.ready = r; e.rdata = rd_w; e.rd = rd; e.wr = wr; e.addr = a; e.wdata = wd;
    return e;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    m_hits = 0; m_misses = 0; m_wbs = 0;
  endfunction

  // Predict the output timeline of one accepted access, starting with the cycle it is driven.
  function automatic void predict(input logic we, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [3:0] be);
    int          idx = int'((a >> 5) % LINES);
    logic [31:0] tag = a >> (5 + IDXW);
    int          w   = int'((a >> 2) & 7);
    logic [31:0] la  = a & ~32'h1F;
    logic [31:0] va;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));      // cycle the request is presented
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));      // tag compare
    if (!(m_valid[idx] && m_tag[idx] == tag)) begin
      m_misses++;
      if (m_valid[idx] && m_dirty[idx]) begin
        m_wbs++;
        va = (m_tag[idx] << (5 + IDXW)) | 32'(idx << 5);
        for (int c = 0; c < MEM_LAT; c++) exp_q.push_back(mk(0, 0, 0, 1, va, m_data[idx]));
        m_mem[va] = m_data[idx];
      end
      for (int c = 0; c < MEM_LAT; c++) exp_q.push_back(mk(0, 0, 1, 0, la, 0));
      m_data[idx]  = m_mem.exists(la) ? m_mem[la] : fill(la);
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tag;
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0));    // second look, now a hit
    end else begin
      m_hits++;
    end
    if (we) begin
      for (int b = 0; b < 4; b++) if (be[b]) m_data[idx][32*w + 8*b +: 8] = wd[8*b +: 8];
      m_dirty[idx] = 1'b1;
      exp_q.push_back(mk(1, 0, 0, 0, 0, 0));
    end else begin
      exp_q.push_back(mk(1, m_data[idx][32*w +: 32], 0, 0, 0, 0));
    end
  endfunction

  // ---------------- per-cycle compare ----------------
  logic chk_en = 1'b0;
  exp_t ce;
  always @(negedge CLK) begin
    if (chk_en) begin
      ce = mk(0, 0, 0, 0, 0, 0);
      if (exp_q.size() != 0) ce = exp_q.pop_front();
      vectors++;
      if (bus.cpu_ready !== ce.ready || bus.mem_read_op !== ce.rd || bus.mem_write_op !== ce.wr
          || (ce.ready && bus.cpu_rdata !== ce.rdata)
          || ((ce.rd || ce.wr) && bus.mem_addr !== ce.addr)
          || (ce.wr && bus.mem_wdata !== ce.wdata)) begin
        miscompares++;
        $display("FAIL cycle t=%0t: ready %b/%b rdata %0h/%0h rd %b/%b wr %b/%b addr %0h/%0h (got/expected)",
                 $time, bus.cpu_ready, ce.ready, bus.cpu_rdata, ce.rdata, bus.mem_read_op, ce.rd,
                 bus.mem_write_op, ce.wr, bus.mem_addr, ce.addr);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, output logic [31:0] rdata, output int lat);
    @(posedge CLK); #1;
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = wd; bus.cpu_be = be;
    wr_cycles = 0; rd_cycles = 0;
    predict(we, a, wd, be);
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
    end while (!bus.cpu_ready && lat < 64);
    check("ready_seen", {255'b0, bus.cpu_ready}, 256'd1);
    if (!bus.cpu_ready) exp_q.delete();
    rdata = bus.cpu_rdata;
  endtask

  task automatic idle(input int n);
    @(posedge CLK); #1;
    bus.cpu_req = 1'b0;
    repeat (n) @(posedge CLK);
  endtask

  task automatic outputs_zero(input string tag);
    check({tag, "_ready"}, {255'b0, bus.cpu_ready}, 256'd0);
    check({tag, "_rdata"}, {224'b0, bus.cpu_rdata}, 256'd0);
    check({tag, "_rd_op"}, {255'b0, bus.mem_read_op}, 256'd0);
    check({tag, "_wr_op"}, {255'b0, bus.mem_write_op}, 256'd0);
    check({tag, "_maddr"}, {224'b0, bus.mem_addr}, 256'd0);
    check({tag, "_mwdata"}, bus.mem_wdata, 256'd0);
  endtask

  logic [31:0] rd;
  int          lat;
  int          n;

  initial begin
    RST_N = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_be = '0;
    bus.mem_rdata = '0;
    model_reset();
    #23;
    outputs_zero("reset");
`ifdef DCACHE_STATS_EN
    check("reset_hit_cnt", {224'b0, hit_cnt}, 256'd0);
`endif
    @(negedge CLK); RST_N = 1'b1;
    @(posedge CLK); #1; chk_en = 1'b1;

    // 1: cold load -> refill of line 0x100, word 0
    access(0, 32'h100, 0, 0, rd, lat);
    check("t1_rdata", {224'b0, rd}, {224'b0, 32'hC0DE_0100});
    check("t1_latency", 256'(lat), 256'd7);
    check("t1_rd_cycles", 256'(rd_cycles), 256'(MEM_LAT));
    // 2: hit on the same line, no memory traffic
    access(0, 32'h104, 0, 0, rd, lat);
    check("t2_rdata", {224'b0, rd}, {224'b0, 32'hC0DE_0104});
    check("t2_latency", 256'(lat), 256'd3);
    check("t2_no_mem", 256'(rd_cycles + wr_cycles), 256'd0);
    // 3: half-word store merges the low half
    access(1, 32'h104, 32'hDEAD_BEEF, 4'b0011, rd, lat);
    check("t3_latency", 256'(lat), 256'd3);
    idle(2);
    access(0, 32'h104, 0, 0, rd, lat);
    check("t3_merged", {224'b0, rd}, {224'b0, 32'hC0DE_BEEF});
    // 4: conflicting load evicts the dirty line
    access(0, 32'h100 + LINES * 32, 0, 0, rd, lat);
    check("t4_latency", 256'(lat), 256'd10);
    check("t4_wb_addr", {224'b0, wb_addr_seen}, {224'b0, 32'h100});
    check("t4_wb_word1", {224'b0, wb_data_seen[63:32]}, {224'b0, 32'hC0DE_BEEF});
    check("t4_wr_cycles", 256'(wr_cycles), 256'(MEM_LAT));
    check("t4_rdata", {224'b0, rd}, {224'b0, 32'hC0DE_0300});
`ifdef DCACHE_STATS_EN
    check("t6_hit_cnt", {224'b0, hit_cnt}, 256'd3);
    check("t6_miss_cnt", {224'b0, miss_cnt}, 256'd2);
    check("t6_wb_cnt", {224'b0, wb_cnt}, 256'd1);
`endif
    // back-to-back stores and loads, partial byte enables
    access(1, 32'h308, 32'h1122_3344, 4'b1111, rd, lat);
    access(0, 32'h308, 0, 0, rd, lat);
    check("b2b_full_word", {224'b0, rd}, {224'b0, 32'h1122_3344});
    access(1, 32'h30C, 32'hAABB_CCDD, 4'b1010, rd, lat);
    access(0, 32'h30C, 0, 0, rd, lat);
    check("be1010_merge", {224'b0, rd}, {224'b0, 32'hAADE_CC0C});
    // be=0 store on a hit still dirties the line
    access(0, 32'h460, 0, 0, rd, lat);
    access(1, 32'h460, 32'hFFFF_FFFF, 4'b0000, rd, lat);
    access(0, 32'h460, 0, 0, rd, lat);
    check("be0_no_change", {224'b0, rd}, {224'b0, 32'hC0DE_0460});
    access(0, 32'h660, 0, 0, rd, lat);
    check("be0_wb_latency", 256'(lat), 256'd10);
    check("be0_wb_addr", {224'b0, wb_addr_seen}, {224'b0, 32'h460});
    // top-of-address-space line, last word
    idle(1);
    access(1, 32'hFFFF_FFFC, 32'h1234_5678, 4'b1111, rd, lat);
    access(0, 32'h1E0, 0, 0, rd, lat);
    check("top_wb_addr", {224'b0, wb_addr_seen}, {224'b0, 32'hFFFF_FFE0});
    check("top_wb_word7", {224'b0, wb_data_seen[255:224]}, {224'b0, 32'h1234_5678});
    access(0, 32'hFFFF_FFFC, 0, 0, rd, lat);
    check("top_reload", {224'b0, rd}, {224'b0, 32'h1234_5678});
    check("top_reload_lat", 256'(lat), 256'd7);
`ifdef DCACHE_STATS_EN
    check("stats_hit", {224'b0, hit_cnt}, 256'(m_hits));
    check("stats_miss", {224'b0, miss_cnt}, 256'(m_misses));
    check("stats_wb", {224'b0, wb_cnt}, 256'(m_wbs));
`endif

    // 5: reset during write-back of dirty line 0x300
    @(posedge CLK); #1;
    chk_en = 1'b0;
    exp_q.delete();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h500;
    n = 0;
    while (!bus.mem_write_op && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check("t5_wb_started", {255'b0, bus.mem_write_op}, 256'd1);
    check("t5_wb_addr", {224'b0, bus.mem_addr}, {224'b0, 32'h300});
    #1 RST_N = 1'b0;
    bus.cpu_req = 1'b0;
    #1;
    outputs_zero("t5_async");
`ifdef DCACHE_STATS_EN
    check("t5_stats_clr", {192'b0, hit_cnt, miss_cnt, wb_cnt}, 256'd0);
`endif
    model_reset();
    @(negedge CLK); RST_N = 1'b1;
    @(posedge CLK); #1; chk_en = 1'b1;
    // all lines invalid: the store to 0x308 is lost, clean refill from RAM
    access(0, 32'h308, 0, 0, rd, lat);
    check("t5_lost_store", {224'b0, rd}, {224'b0, 32'hC0DE_0308});
    check("t5_clean_lat", 256'(lat), 256'd7);
    check("t5_no_wb", 256'(wr_cycles), 256'd0);

    idle(3);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
